// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX/MEM pipeline register with redirect pulse, forwarding tap and optional skid buffer.
// Define EX_MEM_SKID_BUFFER_EN to add a skid entry and make in_ready independent of out_ready.
module ex_mem_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH-1:0]     in_alu_result,
  input  logic [DATA_WIDTH-1:0]     in_store_data,
  input  logic [REG_ADDR_WIDTH-1:0] in_rd,
  input  logic [3:0]                in_ctrl,
  input  logic [2:0]                in_funct3,
  input  logic                      in_branch_taken,
  input  logic [DATA_WIDTH-1:0]     in_branch_target,
  input  logic [DATA_WIDTH-1:0]     in_jalr_target,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     out_alu_result,
  output logic [DATA_WIDTH-1:0]     out_store_data,
  output logic [REG_ADDR_WIDTH-1:0] out_rd,
  output logic [3:0]                out_ctrl,
  output logic [2:0]                out_funct3,
  output logic                      redirect_valid,
  output logic [DATA_WIDTH-1:0]     redirect_pc,
  output logic                      fwd_valid,
  output logic [REG_ADDR_WIDTH-1:0] fwd_rd,
  output logic [DATA_WIDTH-1:0]     fwd_data
);
  localparam int EW = 2 * DATA_WIDTH + REG_ADDR_WIDTH + 7;
  logic [EW-1:0]         in_ent, main_q, main_d;
  logic                  main_valid_q, main_valid_d;
  logic                  redir_valid_q, redir_valid_d;
  logic [DATA_WIDTH-1:0] redir_pc_q, redir_pc_d;
  logic [3:0]            ctrl_raw;
  logic                  accept, drain;
  assign in_ent = {in_alu_result, in_store_data, in_rd, in_ctrl, in_funct3};
  assign {out_alu_result, out_store_data, out_rd, ctrl_raw, out_funct3} = main_q;
  assign out_valid = main_valid_q;
  assign out_ctrl  = main_valid_q ? ctrl_raw : 4'b0;
  assign accept    = in_valid && in_ready;
  assign drain     = main_valid_q && out_ready;
  assign fwd_valid = main_valid_q && ctrl_raw[3] && |out_rd && !ctrl_raw[2];
  assign fwd_rd    = out_rd;
  assign fwd_data  = out_alu_result;
  // jalr wins over a taken branch; the pulse only fires for an accept that survives flush
  assign redir_valid_d  = accept && !flush && (in_branch_taken || in_ctrl[0]);
  assign redir_pc_d     = !redir_valid_d ? redir_pc_q :
                          in_ctrl[0] ? {in_jalr_target[DATA_WIDTH-1:1], 1'b0} : in_branch_target;
  assign redirect_valid = redir_valid_q;
  assign redirect_pc    = redir_pc_q;
`ifdef EX_MEM_SKID_BUFFER_EN
  logic [EW-1:0] skid_q, skid_d;
  logic          skid_valid_q, skid_valid_d;
  assign in_ready = !skid_valid_q || flush;
  // a parked skid entry always refills main before new input; while it is parked in_ready is low
  always_comb begin
    main_d       = main_q;
    main_valid_d = main_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || drain) begin
      main_valid_d = skid_valid_q || accept;
      main_d       = skid_valid_q ? skid_q : accept ? in_ent : main_q;
      skid_valid_d = 1'b0;
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_d       = in_ent;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
    end
  end
`else
  assign in_ready = !main_valid_q || out_ready || flush;
  always_comb begin
    main_valid_d = flush ? 1'b0 : accept ? 1'b1 : drain ? 1'b0 : main_valid_q;
    main_d       = (accept && !flush) ? in_ent : main_q;
  end
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q        <= '0;
      main_valid_q  <= 1'b0;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= '0;
    end else begin
      main_q        <= main_d;
      main_valid_q  <= main_valid_d;
      redir_valid_q <= redir_valid_d;
      redir_pc_q    <= redir_pc_d;
    end
  end
endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, width of the result, store data and PC fields.
REQ-002 Parameter: REG_ADDR_WIDTH, default 5, width of the destination register index.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_valid  input  1  the execute stage presents a completed operation.
REQ-006 in_ready  output  1  the stage accepts the operation this cycle.
REQ-007 in_alu_result  input  DATA_WIDTH  ALU result, or memory address for loads and stores.
REQ-008 in_store_data  input  DATA_WIDTH  rs2 value for stores.
REQ-009 in_rd  input  REG_ADDR_WIDTH  destination register index.
REQ-010 in_ctrl  input  4  control bits {reg_write, mem_read, mem_write, is_jalr}.
REQ-011 in_funct3  input  3  access size and sign for the memory stage.
REQ-012 in_branch_taken  input  1  branch resolved as taken by the ALU.
REQ-013 in_branch_target  input  DATA_WIDTH  PC+imm branch target.
REQ-014 in_jalr_target  input  DATA_WIDTH  rs1+imm JALR target.
REQ-015 flush  input  1  synchronous kill of all held entries.
REQ-016 out_valid / out_ready  output / input  1 / 1  handshake toward the memory stage.
REQ-017 out_alu_result, out_store_data, out_rd, out_ctrl, out_funct3  outputs  same widths as the matching inputs  registered copies of the input fields.
REQ-018 redirect_valid  output  1  one-cycle PC redirect pulse.
REQ-019 redirect_pc  output  DATA_WIDTH  new fetch PC.
REQ-020 fwd_valid  output  1  forwarding data is usable.
REQ-021 fwd_rd  output  REG_ADDR_WIDTH  forwarding register index.
REQ-022 fwd_data  output  DATA_WIDTH  forwarding value.

Function
REQ-023 Transfer rules:
- Input transfer occurs when in_valid && in_ready.
- Output transfer occurs when out_valid && out_ready.
REQ-024 Main register: a single entry that drives all out_* fields. Skid register: one further entry (see REQ-036).
REQ-025 Latency: an accepted operation appears on out_* exactly 1 cycle after acceptance when the main register is empty or drains in the same cycle.
REQ-026 While out_valid=1 and out_ready=0, every out_* field holds stable.
REQ-027 Valid field when the main register is empty: out_valid=0, and out_ctrl reads as 0.
REQ-028 Simultaneous drain and fill: a full main register that drains while a new accept occurs loads the new entry with no bubble.
REQ-029 Redirect pulse:
- The cycle after an accept with in_branch_taken=1, redirect_valid=1 and redirect_pc=in_branch_target.
- The cycle after an accept with is_jalr=1, redirect_valid=1 and redirect_pc=in_jalr_target with bit 0 cleared.
- If both are set on the same accept, is_jalr wins.
- The pulse is exactly one cycle and is independent of out_ready.
REQ-030 Forwarding: fwd_valid = out_valid && reg_write && out_rd!=0 && !mem_read; fwd_rd = out_rd; fwd_data = out_alu_result.
REQ-031 Writes to register 0: entries with rd=0 propagate normally but never assert fwd_valid.
REQ-032 Flush:
- flush=1 clears out_valid, the skid entry and a pending redirect at the next edge.
- An accept in the same cycle as flush is discarded.
- in_ready=1 during flush.
REQ-033 Flush versus redirect: the redirect pulse for an accept made one cycle before flush still fires, because the redirect is what triggers the flush.

Reset
REQ-034 While rst=1, the following are cleared immediately, without waiting for clk:
- out_valid=0, redirect_valid=0, fwd_valid=0;
- skid entry empty;
- all data outputs 0;
- in_ready=1 after deassertion.
REQ-035 Reset asserted mid-transfer discards all held entries; no partial entry emerges after rst falls.

Configuration
REQ-036 With EX_MEM_SKID_BUFFER_EN defined:
- in_ready is a register output, true when the skid entry is empty.
- An accept while out_valid && !out_ready parks the entry in the skid register.
- The skid entry moves to the main register on the next drain, ahead of any new input.
- Throughput is 1 per cycle with no combinational path from out_ready to in_ready.
REQ-037 Without EX_MEM_SKID_BUFFER_EN:
- No skid register exists.
- in_ready = !out_valid || out_ready, combinational.
- All other behaviour is identical.

Verification
REQ-038 Streaming: out_ready=1 with 8 back-to-back accepts of alu_result 0x10..0x17 -> out_alu_result 0x10..0x17 on consecutive cycles starting 1 cycle after the first accept; no bubbles.
REQ-039 Backpressure: hold out_ready=0 for 3 cycles while offering 0xA and 0xB ->
- with the macro: both accepted, out holds 0xA stable, then 0xA and 0xB are delivered in order once out_ready=1;
- without the macro: 0xB is stalled (in_ready=0) until 0xA drains.
REQ-040 Redirect: accept with branch_taken=1, target 0x0000_0200 -> redirect_valid=1 for exactly one cycle with redirect_pc=0x200. Accept with is_jalr=1, jalr_target 0x0000_1003 -> redirect_pc=0x1002.
REQ-041 Forwarding: accept with rd=5, reg_write=1, result 0xDEAD_BEEF -> fwd_valid=1, fwd_rd=5, fwd_data=0xDEADBEEF. Same with rd=0 or mem_read=1 -> fwd_valid=0.
REQ-042 Flush and reset:
- flush while main and skid hold entries and in_valid=1 -> out_valid=0 the next cycle, and nothing is emitted later.
- rst pulsed mid-stream between clock edges -> out_valid and redirect_valid drop immediately.
